// File: rtl/io_pad_arb_pkg.sv
// io_pad_arb_pkg: shared types and constants for the pad turnaround arbiter.
// Holds the FSM state enum and the counter/pointer widths.
package io_pad_arb_pkg;

    localparam int MAX_REQ = 4;
    localparam int BEAT_W  = 8;
    localparam int GUARD_W = 4;
    localparam int PTR_W   = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TURN_ON  = 2'd1,
        DRIVE    = 2'd2,
        TURN_OFF = 2'd3
    } arb_state_e;

endpackage

// File: rtl/io_pad_turnaround_arbiter_if.sv
// io_pad_turnaround_arbiter_if: requester and IO_BUF pin bundle.
// slave = arbiter side; master = requesters plus pad model.
//   REQ/DATA/LAST : per-requester request, serial bit, final-bit flag
//   GNT           : one-hot grant
//   PAD_I/PAD_T   : IO_BUF.I / IO_BUF.T (1 = drive)
//   PAD_O         : IO_BUF.O
//   RX_DATA/VALID : sampled pad value and its qualifier
//   BUSY          : arbiter not idle
interface io_pad_turnaround_arbiter_if #(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0] REQ;
    logic [NUM_REQ-1:0] DATA;
    logic [NUM_REQ-1:0] LAST;
    logic [NUM_REQ-1:0] GNT;
    logic               PAD_I;
    logic               PAD_T;
    logic               PAD_O;
    logic               RX_DATA;
    logic               RX_VALID;
    logic               BUSY;

    modport slave (
        input  REQ,
        input  DATA,
        input  LAST,
        input  PAD_O,
        output GNT,
        output PAD_I,
        output PAD_T,
        output RX_DATA,
        output RX_VALID,
        output BUSY
    );

    modport master (
        output REQ,
        output DATA,
        output LAST,
        output PAD_O,
        input  GNT,
        input  PAD_I,
        input  PAD_T,
        input  RX_DATA,
        input  RX_VALID,
        input  BUSY
    );

endinterface

// File: rtl/rr_arbiter_onehot.sv
// rr_arbiter_onehot: combinational round-robin pick.
// Ports: req (requests), ptr (last granted index) -> gnt_oh, gnt_idx, valid.
// Search starts strictly after ptr and wraps at NUM_REQ-1.
module rr_arbiter_onehot
    import io_pad_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               valid
);

    // Widened copy so a PTR_W index is always in range.
    logic [MAX_REQ-1:0] req_ext;
    logic [PTR_W-1:0]   sel;

    assign req_ext = MAX_REQ'(req);

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        sel     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sel = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!valid && req_ext[sel]) begin
                valid   = 1'b1;
                gnt_idx = sel;
                gnt_oh  = NUM_REQ'(1) << sel;
            end
        end
    end

endmodule

// File: rtl/io_pad_turnaround_arbiter.sv
// io_pad_turnaround_arbiter: round-robin owner of one half-duplex pad.
// Ports: CLK, RST_N (async, active-low), bus (slave modport, see interface).
// Guard cycles surround each drive window; pad is sampled while idle.
module io_pad_turnaround_arbiter
    import io_pad_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TURN_CYCLES = 2,
    parameter int MAX_BURST   = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    io_pad_turnaround_arbiter_if.slave bus
);

    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(TURN_CYCLES - 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0]   PTR_RST    = PTR_W'(NUM_REQ - 1);

    arb_state_e         state_q, state_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_idx_q, win_idx_d;
    logic [NUM_REQ-1:0] win_oh_q, win_oh_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               pad_i_q, pad_i_d;
    logic               pad_t_q, pad_t_d;
    logic               rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] arb_oh;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_valid;

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] data_ext;
    logic [MAX_REQ-1:0] last_ext;
    logic               req_w;
    logic               data_w;
    logic               last_w;
    logic               end_win;

    rr_arbiter_onehot #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (bus.REQ),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    // Signals of the latched winner.
    assign req_ext  = MAX_REQ'(bus.REQ);
    assign data_ext = MAX_REQ'(bus.DATA);
    assign last_ext = MAX_REQ'(bus.LAST);
    assign req_w    = req_ext[win_idx_q];
    assign data_w   = data_ext[win_idx_q];
    assign last_w   = last_ext[win_idx_q];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            guard_q    <= '0;
            beat_q     <= '0;
            ptr_q      <= PTR_RST;
            win_idx_q  <= '0;
            win_oh_q   <= '0;
            gnt_q      <= '0;
            pad_i_q    <= 1'b0;
            pad_t_q    <= 1'b0;
            rx_data_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            guard_q    <= guard_d;
            beat_q     <= beat_d;
            ptr_q      <= ptr_d;
            win_idx_q  <= win_idx_d;
            win_oh_q   <= win_oh_d;
            gnt_q      <= gnt_d;
            pad_i_q    <= pad_i_d;
            pad_t_q    <= pad_t_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        guard_d    = guard_q;
        beat_d     = beat_q;
        ptr_d      = ptr_q;
        win_idx_d  = win_idx_q;
        win_oh_d   = win_oh_q;
        gnt_d      = gnt_q;
        pad_i_d    = pad_i_q;
        pad_t_d    = pad_t_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        end_win    = 1'b0;

        unique case (state_q)
            IDLE: begin
                pad_t_d   = 1'b0;
                rx_data_d = bus.PAD_O;
                if (arb_valid) begin
                    win_idx_d = arb_idx;
                    win_oh_d  = arb_oh;
                    guard_d   = GUARD_LOAD;
                    state_d   = TURN_ON;
                end else begin
                    // Valid only while staying idle, so it is already low
                    // for the whole of TURN_ON.
                    rx_valid_d = 1'b1;
                end
            end
            TURN_ON: begin
                pad_t_d = 1'b0;
                if (guard_q == '0) begin
                    gnt_d   = win_oh_q;
                    beat_d  = '0;
                    ptr_d   = win_idx_q;
                    state_d = DRIVE;
                end else begin
                    guard_d = guard_q - GUARD_W'(1);
                end
            end
            DRIVE: begin
                if (!req_w) begin
                    // Withdrawn request: end without consuming a bit.
                    end_win = 1'b1;
                end else begin
                    pad_i_d = data_w;
                    pad_t_d = 1'b1;
                    beat_d  = beat_q + BEAT_W'(1);
                    end_win = last_w || (beat_q == BEAT_LAST);
                end
                if (end_win) begin
                    gnt_d   = '0;
                    guard_d = GUARD_LOAD;
                    state_d = TURN_OFF;
                end
            end
            TURN_OFF: begin
                // First TURN_OFF edge keeps driving so the final bit
                // gets a full cycle on the pad.
                if (guard_q != GUARD_LOAD) begin
                    pad_t_d = 1'b0;
                end
                if (guard_q == '0) begin
                    state_d = IDLE;
                end else begin
                    guard_d = guard_q - GUARD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.GNT      = gnt_q;
    assign bus.PAD_I    = pad_i_q;
    assign bus.PAD_T    = pad_t_q;
    assign bus.RX_DATA  = rx_data_q;
    assign bus.RX_VALID = rx_valid_q;
    assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_io_pad_turnaround_arbiter.sv
// tb_io_pad_turnaround_arbiter: random requesters vs a window-schedule model.
// Each grant is predicted as a whole window of timed events.
module tb_io_pad_turnaround_arbiter;

    localparam int N  = 3;
    localparam int TC = 2;
    localparam int MB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    io_pad_turnaround_arbiter_if #(.NUM_REQ(N)) bus ();

    io_pad_turnaround_arbiter #(
        .NUM_REQ     (N),
        .TURN_CYCLES (TC),
        .MAX_BURST   (MB)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Requester state: bits consumed, burst length, bit count after
    // which the requester withdraws (== len when it runs to LAST).
    int          len     [N];
    int          pos     [N];
    int          drop_at [N];
    logic [15:0] bits    [N];

    // Window schedule, offsets counted from the arbitration edge.
    bit   win_on;
    int   k, L, G, nc, w, ptr;
    logic exp_pad_i;
    logic exp_rx_data;
    logic pad_o_v;
    bit   load_en;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s got=%0h exp=%0h t=%0t",
                         tag, got, exp, $time);
        end
    endtask

    function automatic bit active(input int i);
        return pos[i] < drop_at[i];
    endfunction

    function automatic int rr_pick(input logic [N-1:0] rq, input int p);
        for (int i = 1; i <= N; i++) begin
            if (rq[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        win_on      = 1'b0;
        k           = 0;
        ptr         = N - 1;
        exp_pad_i   = 1'b0;
        exp_rx_data = 1'b0;
    endtask

    task automatic load_req(input int i, input bit allow_drop);
        len[i]  = 1 + int'($urandom % 7);
        bits[i] = 16'($urandom);
        pos[i]  = 0;
        if (allow_drop && len[i] >= 2 && ($urandom % 5) == 0)
            drop_at[i] = 1 + int'($urandom % (len[i] - 1));
        else
            drop_at[i] = len[i];
    endtask

    task automatic drive_inputs();
        logic [N-1:0] r, d, l;
        r = '0;
        d = '0;
        l = '0;
        for (int i = 0; i < N; i++) begin
            if (active(i)) begin
                r[i] = 1'b1;
                d[i] = bits[i][pos[i]];
                l[i] = (pos[i] == len[i] - 1);
            end else begin
                d[i] = 1'($urandom);
            end
        end
        bus.REQ  = r;
        bus.DATA = d;
        bus.LAST = l;
        bus.PAD_O = pad_o_v;
    endtask

    // One clock edge: predict, clock, compare, then next stimulus.
    task automatic step();
        logic [N-1:0] rq, eg;
        logic         ept, eb, erv;
        int           avail;
        rq = bus.REQ;
        if (!win_on) begin
            exp_rx_data = pad_o_v;
            if (rq != '0) begin
                w     = rr_pick(rq, ptr);
                avail = drop_at[w] - pos[w];
                if (avail >= MB) begin
                    nc = MB;
                    G  = MB;
                end else if (drop_at[w] == len[w]) begin
                    nc = avail;
                    G  = avail;
                end else begin
                    nc = avail;
                    G  = avail + 1;
                end
                L      = 2 * TC + G + 1;
                k      = 0;
                win_on = 1'b1;
            end
        end
        erv = !win_on;
        eg  = '0;
        ept = 1'b0;
        eb  = 1'b0;
        if (win_on) begin
            if (k >= TC && k < TC + G) eg = N'(1) << w;
            ept = (k >= TC + 1 && k <= TC + G + 1);
            eb  = (k < 2 * TC + G);
            if (k >= TC + 1 && k <= TC + nc) begin
                exp_pad_i = bits[w][pos[w]];
                pos[w]++;
            end
            k++;
            if (k == L) begin
                win_on = 1'b0;
                ptr    = w;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("gnt", 32'(bus.GNT), 32'(eg));
        chk("pad_t", 32'(bus.PAD_T), 32'(ept));
        chk("pad_i", 32'(bus.PAD_I), 32'(exp_pad_i));
        chk("busy", 32'(bus.BUSY), 32'(eb));
        chk("rx_valid", 32'(bus.RX_VALID), 32'(erv));
        chk("rx_data", 32'(bus.RX_DATA), 32'(exp_rx_data));
        if (load_en) begin
            for (int i = 0; i < N; i++) begin
                if (!active(i) && !(win_on && w == i) && ($urandom % 4) == 0)
                    load_req(i, 1'b1);
            end
        end
        pad_o_v = 1'($urandom);
        drive_inputs();
    endtask

    function automatic bit all_quiet();
        for (int i = 0; i < N; i++) if (active(i)) return 1'b0;
        return !win_on;
    endfunction

    logic pat [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int   guard_cnt;

    initial begin
        for (int i = 0; i < N; i++) begin
            len[i]     = 0;
            pos[i]     = 0;
            drop_at[i] = 0;
            bits[i]    = '0;
        end
        load_en = 1'b0;
        pad_o_v = 1'b0;
        model_reset();
        drive_inputs();

        #1 rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(bus.GNT), 32'(0));
        chk("rst_pad_t", 32'(bus.PAD_T), 32'(0));
        chk("rst_pad_i", 32'(bus.PAD_I), 32'(0));
        chk("rst_rx_data", 32'(bus.RX_DATA), 32'(0));
        chk("rst_rx_valid", 32'(bus.RX_VALID), 32'(0));
        chk("rst_busy", 32'(bus.BUSY), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Idle listening with a fixed pad pattern.
        for (int j = 0; j < 4; j++) begin
            pad_o_v = pat[j];
            drive_inputs();
            step();
        end

        // Single 4-bit burst 1,0,1,1 from requester 0.
        len[0]     = 4;
        bits[0]    = 16'b1101;
        pos[0]     = 0;
        drop_at[0] = 4;
        drive_inputs();
        for (int j = 0; j < 14; j++) step();

        // Random traffic.
        load_en = 1'b1;
        for (int j = 0; j < 1500; j++) step();

        // Async reset in the middle of a drive window.
        guard_cnt = 0;
        while (!(win_on && k >= TC + 2 && k <= TC + G) && guard_cnt < 800) begin
            step();
            guard_cnt++;
        end
        chk("drive_wait", 32'(guard_cnt < 800), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(bus.GNT), 32'(0));
        chk("mid_rst_pad_t", 32'(bus.PAD_T), 32'(0));
        chk("mid_rst_busy", 32'(bus.BUSY), 32'(0));
        chk("mid_rst_rx_valid", 32'(bus.RX_VALID), 32'(0));
        model_reset();
        for (int i = 0; i < N; i++) load_req(i, 1'b0);
        load_en = 1'b0;
        drive_inputs();
        #1 rst_n = 1'b1;
        for (int j = 0; j <= TC; j++) step();
        chk("rst_first_gnt", 32'(bus.GNT), 32'(1));

        // Drain everything still pending.
        guard_cnt = 0;
        while (!all_quiet() && guard_cnt < 600) begin
            step();
            guard_cnt++;
        end
        chk("drain", 32'(guard_cnt < 600), 32'(1));
        for (int j = 0; j < 3; j++) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
